// File: rtl/xz_scrub_pkg.sv
// Shared types and the X/Z scrub rule for the scrubbing FIFO.
package xz_scrub_pkg;

  typedef logic [7:0] raw_byte_t;
  typedef bit   [7:0] xz_mask_t;

  typedef struct packed {
    byte      data;
    xz_mask_t mask;
  } scrub_entry_t;

  // A bit that is neither a clean 0 nor a clean 1 is X or Z. It is replaced by
  // fill and flagged in the mask. Testing for "not 0 and not 1" keeps this
  // correct on both 4-state and 2-state evaluators.
  function automatic scrub_entry_t scrub(raw_byte_t v, bit fill);
    scrub_entry_t r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r.mask[i] = (v[i] !== 1'b0) && (v[i] !== 1'b1);
      r.data[i] = r.mask[i] ? fill : v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/xz_byte_scrub.sv
// Combinational scrubber: 4-state byte in, clean data plus X/Z mask out.
module xz_byte_scrub
  import xz_scrub_pkg::*;
#(
  parameter bit FILL = 1'b0
) (
  input  raw_byte_t    in_data,
  output scrub_entry_t entry
);

  assign entry = scrub(in_data, FILL);

endmodule

// File: rtl/xz_scrub_fifo.sv
// Scrubbing FIFO: cleans X/Z bits off incoming bytes, buffers the clean byte
// with its contamination mask, and counts contaminated bytes (saturating).
module xz_scrub_fifo
  import xz_scrub_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit FILL  = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  raw_byte_t                in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output byte                      out_data,
  output xz_mask_t                 out_xz_mask,
  output bit [CNT_W-1:0]           xz_count,
  output bit [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  scrub_entry_t  mem [DEPTH];
  scrub_entry_t  in_entry;
  scrub_entry_t  head;
  logic          push;
  logic          pop;

  xz_byte_scrub #(.FILL(FILL)) u_scrub (
    .in_data (in_data),
    .entry   (in_entry)
  );

  // Handshake decode; an X/Z on a valid/ready strobe never counts as asserted.
  // in_ready is gated by rst_n so it drops the moment reset is applied.
  assign in_ready  = rst_n && (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = (in_valid === 1'b1) && in_ready;
  assign pop       = out_valid && (out_ready === 1'b1);

  // Head is read combinationally; outputs are zeroed when empty so nothing
  // stale or undefined escapes.
  assign head        = mem[rd_ptr];
  assign out_data    = out_valid ? head.data : 8'h00;
  assign out_xz_mask = out_valid ? head.mask : 8'h00;

  // Entry storage, written on push only; contents are not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers, occupancy and the saturating contamination counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      xz_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && (in_entry.mask != '0) && (xz_count != '1)) begin
        xz_count <= xz_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xz_scrub_fifo.sv
// Directed bench for xz_scrub_fifo: three instances (default, FILL=1, CNT_W=2)
// share one stimulus stream; each scenario task checks its own outputs.
module tb_xz_scrub_fifo;
  import xz_scrub_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       d_in_ready, d_out_valid;
  byte        d_out_data;
  xz_mask_t   d_mask;
  bit [7:0]   d_xz_count;
  bit [2:0]   d_level;

  logic       f_in_ready, f_out_valid;
  byte        f_out_data;
  xz_mask_t   f_mask;
  bit [7:0]   f_xz_count;
  bit [2:0]   f_level;

  logic       c_in_ready, c_out_valid;
  byte        c_out_data;
  xz_mask_t   c_mask;
  bit [1:0]   c_xz_count;
  bit [2:0]   c_level;

  int         errors = 0;
  int         checks = 0;
  bit         four_state;
  logic       probe;
  bit [7:0]   exp_cnt;
  bit [1:0]   exp_cnt2;

  always #5 clk = ~clk;

  xz_scrub_fifo #(.DEPTH(4), .FILL(1'b0), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_data(in_data), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_data(d_out_data), .out_xz_mask(d_mask), .xz_count(d_xz_count), .level(d_level)
  );

  xz_scrub_fifo #(.DEPTH(4), .FILL(1'b1), .CNT_W(8)) u_fill1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_data(in_data), .out_valid(f_out_valid), .out_ready(out_ready),
    .out_data(f_out_data), .out_xz_mask(f_mask), .xz_count(f_xz_count), .level(f_level)
  );

  xz_scrub_fifo #(.DEPTH(4), .FILL(1'b0), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_xz_mask(c_mask), .xz_count(c_xz_count), .level(c_level)
  );

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", d_in_ready); end
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", d_out_valid); end
    checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", d_level); end
    checks++; if (d_xz_count !== 8'd0) begin errors++; $display("FAIL reset_xz_count: got %0d expected 0", d_xz_count); end
    checks++; if (d_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", d_out_data); end
    checks++; if (d_mask !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h expected 00", d_mask); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", d_in_ready); end
    exp_cnt = '0;
    exp_cnt2 = '0;
    $display("reset done");
  endtask

  task automatic test_single();
    @(negedge clk);
    in_data = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    $display("push a5, head %h", d_out_data);
    checks++; if (d_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", d_out_valid); end
    checks++; if (d_out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", d_out_data); end
    checks++; if (d_mask !== 8'h00) begin errors++; $display("FAIL single_mask: got %h expected 00", d_mask); end
    checks++; if (d_xz_count !== 8'd0) begin errors++; $display("FAIL single_count: got %0d expected 0", d_xz_count); end
    checks++; if (d_level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", d_level); end
    @(negedge clk);
    $display("pop a5");
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL single_empty_valid: got %b expected 0", d_out_valid); end
    checks++; if (d_out_data !== 8'h00) begin errors++; $display("FAIL single_empty_data: got %h expected 00", d_out_data); end
    checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL single_empty_level: got %0d expected 0", d_level); end
    out_ready = 1'b0;
  endtask

  task automatic test_scrub();
    logic [7:0] exp_d, exp_f;
    bit [7:0]   exp_m;
    @(negedge clk);
    out_ready = 1'b0;
    in_data = 8'b1x0z_01x1;
    in_valid = 1'b1;
    if (four_state) begin
      exp_d = 8'b1000_0101; exp_f = 8'b1101_0111; exp_m = 8'b0101_0010;
      if (exp_cnt != 8'hFF) exp_cnt++;
      if (exp_cnt2 != 2'd3) exp_cnt2++;
    end else begin
      // A 2-state evaluator has already resolved X/Z; the byte passes as held.
      exp_d = in_data; exp_f = in_data; exp_m = 8'h00;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'hxx;
    $display("push 1x0z01x1, head fill0 %h fill1 %h mask %h", d_out_data, f_out_data, d_mask);
    checks++; if (d_out_data !== exp_d) begin errors++; $display("FAIL scrub_fill0_data: got %h expected %h", d_out_data, exp_d); end
    checks++; if (d_mask !== exp_m) begin errors++; $display("FAIL scrub_mask: got %h expected %h", d_mask, exp_m); end
    checks++; if (f_out_data !== exp_f) begin errors++; $display("FAIL scrub_fill1_data: got %h expected %h", f_out_data, exp_f); end
    checks++; if (f_mask !== exp_m) begin errors++; $display("FAIL scrub_fill1_mask: got %h expected %h", f_mask, exp_m); end
    checks++; if (d_xz_count !== exp_cnt) begin errors++; $display("FAIL scrub_count: got %0d expected %0d", d_xz_count, exp_cnt); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_data = 8'h00;
    checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL scrub_drained_level: got %0d expected 0", d_level); end
    checks++; if (d_xz_count !== exp_cnt) begin errors++; $display("FAIL scrub_count_after_pop: got %0d expected %0d", d_xz_count, exp_cnt); end
  endtask

  task automatic test_full_drain();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i);
      in_valid = 1'b1;
      @(negedge clk);
      $display("push %h, level %0d, in_ready %b", 8'(i), d_level, d_in_ready);
      checks++; if (d_level !== 3'((i < 4) ? i : 4)) begin errors++; $display("FAIL full_level_%0d: got %0d expected %0d", i, d_level, (i < 4) ? i : 4); end
      checks++; if (d_in_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL full_in_ready_%0d: got %b expected %b", i, d_in_ready, (i < 4)); end
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      $display("pop %h", d_out_data);
      checks++; if (d_out_data !== 8'(k)) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", k, d_out_data, 8'(k)); end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", d_level); end
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", d_out_valid); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'h10 + 8'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    checks++; if (d_level !== 3'd4) begin errors++; $display("FAIL fullpop_filled: got %0d expected 4", d_level); end
    in_data = 8'h15;
    out_ready = 1'b1;
    @(negedge clk);
    $display("full push+pop, level %0d head %h", d_level, d_out_data);
    checks++; if (d_level !== 3'd3) begin errors++; $display("FAIL fullpop_level: got %0d expected 3", d_level); end
    checks++; if (d_out_data !== 8'h12) begin errors++; $display("FAIL fullpop_head: got %h expected 12", d_out_data); end
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready: got %b expected 1", d_in_ready); end
    @(negedge clk);
    $display("push 15 + pop, level %0d head %h", d_level, d_out_data);
    checks++; if (d_level !== 3'd3) begin errors++; $display("FAIL both_level: got %0d expected 3", d_level); end
    checks++; if (d_out_data !== 8'h13) begin errors++; $display("FAIL both_head: got %h expected 13", d_out_data); end
    in_valid = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      checks++; if (d_out_data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL wrap_data_%0d: got %h expected %h", k, d_out_data, 8'h10 + 8'(k)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL wrap_level: got %0d expected 0", d_level); end
  endtask

  task automatic test_counter();
    logic [7:0] raw;
    bit [7:0]   exp_m;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      raw = 8'h20 + 8'(i);
      raw[i] = 1'bz;
      in_data = raw;
      in_valid = 1'b1;
      if (four_state) begin
        exp_m = 8'h01 << i;
        if (exp_cnt != 8'hFF) exp_cnt++;
        if (exp_cnt2 != 2'd3) exp_cnt2++;
      end else begin
        exp_m = 8'h00;
      end
      @(negedge clk);
      $display("push z-byte %0d, cnt2 %0d, cnt8 %0d", i, c_xz_count, d_xz_count);
      checks++; if (c_xz_count !== exp_cnt2) begin errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", i, c_xz_count, exp_cnt2); end
      checks++; if (d_xz_count !== exp_cnt) begin errors++; $display("FAIL wide_count_%0d: got %0d expected %0d", i, d_xz_count, exp_cnt); end
      checks++; if (c_mask !== exp_m) begin errors++; $display("FAIL sat_mask_%0d: got %h expected %h", i, c_mask, exp_m); end
      checks++; if (c_level !== 3'd1) begin errors++; $display("FAIL sat_level_%0d: got %0d expected 1", i, c_level); end
    end
    in_valid = 1'b0;
    in_data = 8'h00;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (c_xz_count !== exp_cnt2) begin errors++; $display("FAIL sat_count_after_pop: got %0d expected %0d", c_xz_count, exp_cnt2); end
  endtask

  task automatic test_reset_mid();
    bit v_seen;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'h30 + 8'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (d_level !== 3'd3) begin errors++; $display("FAIL mid_prefill: got %0d expected 3", d_level); end
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-stream, level %0d", d_level);
    checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", d_out_valid); end
    checks++; if (d_level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", d_level); end
    checks++; if (d_xz_count !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", d_xz_count); end
    checks++; if (c_xz_count !== 2'd0) begin errors++; $display("FAIL mid_count2: got %0d expected 0", c_xz_count); end
    checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", d_in_ready); end
    checks++; if (d_out_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h expected 00", d_out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'bx;
    in_data = 8'h77;
    v_seen = (in_valid === 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    $display("in_valid=x offered, level %0d", d_level);
    checks++; if (d_level !== 3'(four_state ? 1'b0 : v_seen)) begin errors++; $display("FAIL xvalid_level: got %0d expected %0d", d_level, four_state ? 1'b0 : v_seen); end
  endtask

  initial begin
    probe = 1'bx;
    four_state = (probe !== 1'b0) && (probe !== 1'b1);
    test_reset();
    test_single();
    test_scrub();
    test_full_drain();
    test_full_pop();
    test_counter();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
